// File: rtl/btn_event_ctrl.sv
// Turns debounced button levels into a stream of PRESS/LONG/REPEAT/RELEASE events,
// with one shared hold/repeat timer and a single-entry valid/ready output slot.
module btn_event_ctrl #(
  parameter int NUM_BTN    = 4,
  parameter int HOLD_CYC   = 8,
  parameter int REPEAT_CYC = 4,
  localparam int ID_W      = $clog2(NUM_BTN),
  localparam int CNT_W     = $clog2(((HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC) + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_db,
  output logic               evt_valid,
  input  logic               evt_ready,
  output logic [ID_W-1:0]    evt_id,
  output logic [1:0]         evt_type,
  output logic               busy
);

  typedef enum logic [2:0] {
    IDLE, EMIT_PRESS, HOLD, EMIT_LONG, REPEAT, EMIT_REP, EMIT_REL
  } state_t;

  localparam logic [1:0] EV_PRESS   = 2'b00;
  localparam logic [1:0] EV_LONG    = 2'b01;
  localparam logic [1:0] EV_REPEAT  = 2'b10;
  localparam logic [1:0] EV_RELEASE = 2'b11;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [ID_W-1:0]    owner, owner_nxt, rise_idx;
  logic [NUM_BTN-1:0] btn_q, rise;
  logic               free, emit, owner_lvl;
  logic [1:0]         emit_type;

  assign rise      = btn_db & ~btn_q;
  assign free      = ~evt_valid | evt_ready;
  assign owner_lvl = btn_db[owner];

  // Lowest-index rise wins; simultaneous rises on other buttons are dropped.
  always_comb begin
    rise_idx = '0;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (rise[i]) rise_idx = ID_W'(i);
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    owner_nxt = owner;
    emit      = 1'b0;
    emit_type = EV_PRESS;
    case (state)
      IDLE: begin
        if (|rise) begin
          owner_nxt = rise_idx;
          state_nxt = EMIT_PRESS;
        end
      end
      EMIT_PRESS: begin
        if (free) begin
          emit      = 1'b1;
          emit_type = EV_PRESS;
          cnt_nxt   = '0;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (!owner_lvl)                          state_nxt = EMIT_REL;
        else if (cnt == CNT_W'(HOLD_CYC - 1))    state_nxt = EMIT_LONG;
        else                                     cnt_nxt   = cnt + CNT_W'(1);
      end
      EMIT_LONG: begin
        if (free) begin
          emit      = 1'b1;
          emit_type = EV_LONG;
          cnt_nxt   = '0;
          state_nxt = REPEAT;
        end
      end
      REPEAT: begin
        if (!owner_lvl)                          state_nxt = EMIT_REL;
        else if (cnt == CNT_W'(REPEAT_CYC - 1))  state_nxt = EMIT_REP;
        else                                     cnt_nxt   = cnt + CNT_W'(1);
      end
      EMIT_REP: begin
        if (free) begin
          emit      = 1'b1;
          emit_type = EV_REPEAT;
          cnt_nxt   = '0;
          state_nxt = REPEAT;
        end
      end
      EMIT_REL: begin
        if (free) begin
          emit      = 1'b1;
          emit_type = EV_RELEASE;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      owner     <= '0;
      btn_q     <= '0;
      busy      <= 1'b0;
      evt_valid <= 1'b0;
      evt_id    <= '0;
      evt_type  <= EV_PRESS;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      owner <= owner_nxt;
      btn_q <= btn_db;
      busy  <= (state_nxt != IDLE);
      // A new event may replace the one being accepted in the same cycle.
      if (emit) begin
        evt_valid <= 1'b1;
        evt_id    <= owner;
        evt_type  <= emit_type;
      end else if (evt_ready) begin
        evt_valid <= 1'b0;
      end
    end
  end

endmodule
